// File: rtl/encoder_bitscan_2pnxn.sv
// Sequential 2**N-to-N bit-scan encoder: takes one vector per input handshake and
// emits the index of each set bit, one per output beat, lowest- or highest-first.
module encoder_bitscan_2pnxn #(
    parameter int unsigned N         = 5,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [2**N-1:0]   IN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [N-1:0]      OUT,
    output logic [N:0]        OUT_SEQ,
    output logic              OUT_LAST,
    output logic              OUT_ZERO
);

    localparam int unsigned W = 2**N;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StScan = 1'b1;

    localparam logic [W-1:0] OneW   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [N:0]   OneSeq = {{N{1'b0}}, 1'b1};

    logic [0:0]   state_q, state_d;
    logic [W-1:0] pend_q, pend_d;
    logic [N:0]   seq_q, seq_d;
    logic         zflag_q, zflag_d;

    logic [N-1:0] hit_idx;
    logic [W-1:0] hit_mask;
    logic         single;
    logic         scan;
    logic         last;
    logic         out_fire;
    logic         in_ready;
    logic         in_fire;

    // Priority-encode the pending bits; later loop iterations win, so the scan
    // direction picks which end of the vector has priority.
    always_comb begin
        hit_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < W; i++) begin
                if (pend_q[i]) begin
                    hit_idx = i[N-1:0];
                end
            end
        end else begin
            for (int i = W - 1; i >= 0; i--) begin
                if (pend_q[i]) begin
                    hit_idx = i[N-1:0];
                end
            end
        end
        hit_mask = OneW << hit_idx;
    end

    // Handshake decode; a last beat frees the input port in the same cycle.
    always_comb begin
        scan     = (state_q == StScan);
        single   = (pend_q != '0) && ((pend_q & (pend_q - OneW)) == '0);
        last     = zflag_q || single;
        out_fire = scan && OUT_READY;
        in_ready = !scan || (OUT_READY && last);
        in_fire  = IN_VALID && in_ready;
    end

    // Next-state: a new vector load takes precedence over retiring the last beat.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        seq_d   = seq_q;
        zflag_d = zflag_q;
        if (in_fire) begin
            state_d = StScan;
            pend_d  = IN;
            seq_d   = '0;
            zflag_d = (IN == '0);
        end else if (out_fire) begin
            if (last) begin
                // Clear leftovers so idle outputs stay at zero.
                state_d = StIdle;
                pend_d  = '0;
                seq_d   = '0;
                zflag_d = 1'b0;
            end else begin
                pend_d = pend_q & ~hit_mask;
                seq_d  = seq_q + OneSeq;
            end
        end
    end

    // State registers with synchronous reset that overrides any handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            pend_q  <= '0;
            seq_q   <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
            zflag_q <= zflag_d;
        end
    end

    // Outputs are forced to zero whenever no beat is presented.
    always_comb begin
        IN_READY  = in_ready;
        OUT_VALID = scan;
        OUT       = scan ? hit_idx : '0;
        OUT_SEQ   = scan ? seq_q : '0;
        OUT_LAST  = scan && last;
        OUT_ZERO  = scan && zflag_q;
    end

endmodule
